sys_arr_row_sequencer: RTL and testbench
========================================

// Module: sys_arr_row_sequencer
// PURPOSE
//  Memory-side initiator for the systolic array memory interface. Accepts jobs and row data from the
//  tile buffer and sequences weight/input/partial row loads into the array, gated on drained /
//  fifo_has_space. Captures array output rows into a small buffer drained by a valid/ready port.
// PARAMETERS
//  N          4    array dimension (rows per matrix, elements per row); matches sys_arr_pkg
//  DW         16   element width in bits; matches sys_arr_pkg
//  ROW_GAP    1    idle cycles inserted after every input/partial row load (0..15)
//  OUT_DEPTH  4    output-row buffer entries (power of 2, >=2)
// PORTS
//  clk               in   1          clock
//  RST               in   1          reset: asynchronous, active-high
//  job_valid         in   1          job request valid
//  job_has_weights   in   1          job begins with N weight rows
//  job_ready         out  1          job accepted when valid&ready
//  row_valid         in   1          row stream valid
//  row_data          in   N*DW       weight row or input row
//  row_partial       in   N*DW       partial-sum row (ignored for weight rows)
//  row_ready         out  1          row accepted when valid&ready
//  job_done          out  1          1-cycle pulse when last input row issued to array
//  weight_en, input_en, partial_en  out 1   array load strobes
//  row_in_en         out  $clog2(N)  input/weight row index
//  row_ps_en         out  $clog2(N)  partial row index
//  array_in          out  N*DW       row data to array
//  array_in_partials out  N*DW       partial data to array
//  drained           in   1          array empty; safe to reload weights
//  fifo_has_space    in   1          array input FIFO can take N more rows
//  out_en            in   1          array output row strobe
//  row_out           in   $clog2(N)  index of output row
//  array_output      in   N*DW       output row data
//  out_valid/out_ready  out/in 1     output buffer handshake
//  out_row           out  $clog2(N)  buffered row index
//  out_data          out  N*DW       buffered row data
//  out_overflow      out  1          sticky: out_en arrived while buffer full
// BEHAVIOUR
//  - RST: all outputs 0, FSM=IDLE, counters 0, buffer empty, out_overflow cleared. Strobes drop at once.
//  - FSM: IDLE -> (job_valid) WAIT_DRAIN if job_has_weights else WAIT_SPACE; job_ready=1 only in IDLE.
//    WAIT_DRAIN -> LOAD_W when drained=1. LOAD_W: accept N rows, then -> WAIT_SPACE.
//    WAIT_SPACE -> LOAD_IN when fifo_has_space=1. LOAD_IN: accept one row -> GAP (ROW_GAP cycles) or
//    LOAD_IN directly if ROW_GAP=0; after row N-1 -> IDLE with job_done pulse.
//  - row_ready=1 only in LOAD_W/LOAD_IN. row_valid=0 stalls: no strobe, row counter holds.
//  - Latency: row accepted in cycle t -> strobe + index + data registered, high exactly cycle t+1;
//    all strobes/data return to 0 in the next cycle unless another row is accepted.
//  - Weight row: weight_en=1, row_in_en=r, row_ps_en=0, array_in_partials=0.
//  - Input row: input_en=partial_en=1, row_in_en=row_ps_en=r. Row counter wraps N-1 -> 0 per phase.
//  - job_done asserts in the same cycle as the last input strobe.
//  - Output buffer: circular FIFO of {row_out,array_output}; push on out_en, pop on out_valid&out_ready.
//    Simultaneous push+pop when full: both succeed, no overflow. Push when full without pop: entry
//    dropped, out_overflow set until RST. out_valid=!empty; out_row/out_data show head entry.
//  - Drained/fifo_has_space sampled each cycle in wait states only; ignored elsewhere.
// CONFIGURATION
//  SA_SEQ_PERF_EN defined: adds outputs stall_cycles[31:0] (cycles in WAIT_DRAIN/WAIT_SPACE or
//    LOAD_* with row_valid=0) and jobs_done[15:0] (increments per job_done); saturating, cleared by RST.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Weight job, N=4, drained=1, rows valid back-to-back -> weight_en on 4 consecutive cycles rows 0..3,
//    then input rows with 1-cycle gaps; job_done with row 3 input strobe.
//  2 Input-only job, fifo_has_space=0 for 10 cycles then 1 -> no strobes/row_ready during wait; loads
//    begin cycle after space seen.
//  3 row_valid low 3 cycles mid LOAD_IN -> no strobes, row index resumes at same r.
//  4 out_en 5 rows with out_ready=0, OUT_DEPTH=4 -> 4 entries held, out_overflow=1; pop gives rows in order.
//  5 Full buffer, out_en and out_ready same cycle -> count unchanged, out_overflow stays 0.
//  6 RST asserted during LOAD_IN row 2 -> strobes 0 immediately; after release job_ready=1, new job restarts at row 0.

Source files
------------

// File: rtl/sys_arr_row_sequencer.sv
// Sequences weight/input/partial row loads into the systolic array and buffers its output rows.
// Define SA_SEQ_PERF_EN to add the stall_cycles / jobs_done performance counters.
module sys_arr_row_sequencer #(
    parameter int N         = 4,
    parameter int DW        = 16,
    parameter int ROW_GAP   = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 job_valid,
    input  logic                 job_has_weights,
    output logic                 job_ready,
    input  logic                 row_valid,
    input  logic [N*DW-1:0]      row_data,
    input  logic [N*DW-1:0]      row_partial,
    output logic                 row_ready,
    output logic                 job_done,
    output logic                 weight_en,
    output logic                 input_en,
    output logic                 partial_en,
    output logic [$clog2(N)-1:0] row_in_en,
    output logic [$clog2(N)-1:0] row_ps_en,
    output logic [N*DW-1:0]      array_in,
    output logic [N*DW-1:0]      array_in_partials,
    input  logic                 drained,
    input  logic                 fifo_has_space,
    input  logic                 out_en,
    input  logic [$clog2(N)-1:0] row_out,
    input  logic [N*DW-1:0]      array_output,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_row,
    output logic [N*DW-1:0]      out_data,
    output logic                 out_overflow
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          jobs_done
`endif
);
    localparam int IW = $clog2(N);
    localparam int RW = N * DW;
    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);
    localparam logic [3:0]    GAP_INIT = 4'(ROW_GAP - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(OUT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DRAIN, S_LOAD_W, S_WAIT_SPACE, S_LOAD_IN, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   row_q, row_d;
    logic [3:0]      gap_q, gap_d;
    logic            weight_en_q, weight_en_d;
    logic            input_en_q, input_en_d;
    logic            partial_en_q, partial_en_d;
    logic            job_done_q, job_done_d;
    logic [IW-1:0]   row_in_en_q, row_in_en_d;
    logic [IW-1:0]   row_ps_en_q, row_ps_en_d;
    logic [RW-1:0]   array_in_q, array_in_d;
    logic [RW-1:0]   array_in_partials_q, array_in_partials_d;

    logic [IW+RW-1:0] mem_q [OUT_DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, push, pop;

    always_comb begin
        state_d             = state_q;
        row_d               = row_q;
        gap_d               = gap_q;
        weight_en_d         = 1'b0;
        input_en_d          = 1'b0;
        partial_en_d        = 1'b0;
        job_done_d          = 1'b0;
        row_in_en_d         = '0;
        row_ps_en_d         = '0;
        array_in_d          = '0;
        array_in_partials_d = '0;
        // job_ready is masked while RST is high so every output reads 0 in reset
        job_ready           = (state_q == S_IDLE) && !RST;
        row_ready           = (state_q == S_LOAD_W) || (state_q == S_LOAD_IN);
        case (state_q)
            S_IDLE: begin
                if (job_valid) state_d = job_has_weights ? S_WAIT_DRAIN : S_WAIT_SPACE;
            end
            S_WAIT_DRAIN: begin
                if (drained) state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (row_valid) begin
                    weight_en_d = 1'b1;
                    row_in_en_d = row_q;
                    array_in_d  = row_data;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_WAIT_SPACE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (fifo_has_space) state_d = S_LOAD_IN;
            end
            S_LOAD_IN: begin
                if (row_valid) begin
                    input_en_d          = 1'b1;
                    partial_en_d        = 1'b1;
                    row_in_en_d         = row_q;
                    row_ps_en_d         = row_q;
                    array_in_d          = row_data;
                    array_in_partials_d = row_partial;
                    if (row_q == LAST_ROW) begin
                        row_d      = '0;
                        job_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                        if (ROW_GAP != 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_INIT;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_LOAD_IN;
                else               gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output buffer: a push into a full buffer still lands when the head pops that same cycle
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign pop   = !empty && out_ready;
    assign push  = out_en && (!full || pop);

    always_comb begin
        rd_d  = pop  ? rd_q + 1'b1 : rd_q;
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        ovf_d = ovf_q || (out_en && full && !pop);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q             <= S_IDLE;
            row_q               <= '0;
            gap_q               <= '0;
            weight_en_q         <= 1'b0;
            input_en_q          <= 1'b0;
            partial_en_q        <= 1'b0;
            job_done_q          <= 1'b0;
            row_in_en_q         <= '0;
            row_ps_en_q         <= '0;
            array_in_q          <= '0;
            array_in_partials_q <= '0;
            rd_q                <= '0;
            wr_q                <= '0;
            cnt_q               <= '0;
            ovf_q               <= 1'b0;
        end else begin
            state_q             <= state_d;
            row_q               <= row_d;
            gap_q               <= gap_d;
            weight_en_q         <= weight_en_d;
            input_en_q          <= input_en_d;
            partial_en_q        <= partial_en_d;
            job_done_q          <= job_done_d;
            row_in_en_q         <= row_in_en_d;
            row_ps_en_q         <= row_ps_en_d;
            array_in_q          <= array_in_d;
            array_in_partials_q <= array_in_partials_d;
            rd_q                <= rd_d;
            wr_q                <= wr_d;
            cnt_q               <= cnt_d;
            ovf_q               <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {row_out, array_output};
    end

    assign weight_en         = weight_en_q;
    assign input_en          = input_en_q;
    assign partial_en        = partial_en_q;
    assign job_done          = job_done_q;
    assign row_in_en         = row_in_en_q;
    assign row_ps_en         = row_ps_en_q;
    assign array_in          = array_in_q;
    assign array_in_partials = array_in_partials_q;
    assign out_valid         = !empty;
    assign out_overflow      = ovf_q;
    assign {out_row, out_data} = empty ? '0 : mem_q[rd_q];

`ifdef SA_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] jobs_q, jobs_d;
    logic        stall_now;

    always_comb begin
        stall_now = (state_q == S_WAIT_DRAIN) || (state_q == S_WAIT_SPACE) ||
                    (((state_q == S_LOAD_W) || (state_q == S_LOAD_IN)) && !row_valid);
        stall_d   = (stall_now && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
        jobs_d    = (job_done_q && (jobs_q != '1)) ? jobs_q + 1'b1 : jobs_q;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            jobs_q  <= '0;
        end else begin
            stall_q <= stall_d;
            jobs_q  <= jobs_d;
        end
    end

    assign stall_cycles = stall_q;
    assign jobs_done    = jobs_q;
`endif
endmodule

// File: tb/tb_sys_arr_row_sequencer.sv
// Bench for sys_arr_row_sequencer: cycle table for a weight job, directed corner sequences,
// and a randomized output-buffer run against a queue model.
module tb_sys_arr_row_sequencer;
    localparam int N = 4, DW = 16, RW = 64, DEPTH = 4;

    logic clk = 1'b0;
    logic RST;
    logic job_valid, job_has_weights, job_ready;
    logic row_valid, row_ready, job_done;
    logic [RW-1:0] row_data, row_partial, array_in, array_in_partials, array_output, out_data;
    logic weight_en, input_en, partial_en;
    logic [1:0] row_in_en, row_ps_en, row_out, out_row;
    logic drained, fifo_has_space, out_en, out_valid, out_ready, out_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sys_arr_row_sequencer #(.N(N), .DW(DW), .ROW_GAP(1), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST),
        .job_valid(job_valid), .job_has_weights(job_has_weights), .job_ready(job_ready),
        .row_valid(row_valid), .row_data(row_data), .row_partial(row_partial),
        .row_ready(row_ready), .job_done(job_done),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .drained(drained), .fifo_has_space(fifo_has_space),
        .out_en(out_en), .row_out(row_out), .array_output(array_output),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .out_overflow(out_overflow)
    );

    typedef struct {
        bit jv, hw, rv, dr, sp;
        bit jr, rr, we, ie, jd;
        int idx;
        int step;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] dpat(input int s);
        return {4{16'(16'h0A00 + s)}};
    endfunction

    function automatic logic [63:0] opat(input int k);
        return {4{16'(16'hB000 + k)}};
    endfunction

    // Runs an input phase to completion, checking row order and the job_done pulse.
    task automatic finish_job(input int first_idx, input string nm);
        int exp_idx;
        exp_idx = first_idx;
        for (int c = 0; c < 60 && exp_idx < N; c++) begin
            @(negedge clk);
            if (input_en) begin
                chk({nm, " idx"}, 64'(row_in_en), 64'(exp_idx));
                chk({nm, " ps_idx"}, 64'(row_ps_en), 64'(exp_idx));
                chk({nm, " job_done"}, 64'(job_done), 64'(exp_idx == N - 1));
                exp_idx++;
            end
        end
        chk({nm, " rows issued"}, 64'(exp_idx), 64'(N));
    endtask

    task automatic drain_expect(input int first_k, input int cnt, input string nm);
        for (int j = 0; j < cnt; j++) begin
            chk({nm, " valid"}, 64'(out_valid), 64'd1);
            chk({nm, " row"}, 64'(out_row), 64'((first_k + j) % 4));
            chk({nm, " data"}, out_data, opat(first_k + j));
            out_ready = 1'b1;
            @(negedge clk);
        end
        chk({nm, " empty after"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    logic [65:0] mq[$];
    bit          m_ovf;

    initial begin
        #400000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        RST = 1'b1;
        job_valid = 0; job_has_weights = 0; row_valid = 0; drained = 0; fifo_has_space = 0;
        row_data = '0; row_partial = '0; out_en = 0; row_out = '0; array_output = '0; out_ready = 0;

        tbl[0]  = '{1,1,1,1,1, 1,0,0,0,0, 0,-1};
        tbl[1]  = '{0,0,1,1,1, 0,0,0,0,0, 0,-1};
        tbl[2]  = '{0,0,1,1,1, 0,1,0,0,0, 0,-1};
        tbl[3]  = '{0,0,1,1,1, 0,1,1,0,0, 0, 2};
        tbl[4]  = '{0,0,1,1,1, 0,1,1,0,0, 1, 3};
        tbl[5]  = '{0,0,1,1,1, 0,1,1,0,0, 2, 4};
        tbl[6]  = '{0,0,1,1,1, 0,0,1,0,0, 3, 5};
        tbl[7]  = '{0,0,1,1,1, 0,1,0,0,0, 0,-1};
        tbl[8]  = '{0,0,1,1,1, 0,0,0,1,0, 0, 7};
        tbl[9]  = '{0,0,1,1,1, 0,1,0,0,0, 0,-1};
        tbl[10] = '{0,0,1,1,1, 0,0,0,1,0, 1, 9};
        tbl[11] = '{0,0,1,1,1, 0,1,0,0,0, 0,-1};
        tbl[12] = '{0,0,1,1,1, 0,0,0,1,0, 2,11};
        tbl[13] = '{0,0,1,1,1, 0,1,0,0,0, 0,-1};
        tbl[14] = '{0,0,1,1,1, 1,0,0,1,1, 3,13};
        tbl[15] = '{0,0,1,1,1, 1,0,0,0,0, 0,-1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst job_ready", 64'(job_ready), 64'd0);
        chk("rst row_ready", 64'(row_ready), 64'd0);
        chk("rst strobes", 64'({weight_en, input_en, partial_en, job_done}), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst overflow", 64'(out_overflow), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        RST = 1'b0;

        // Weight job cycle table
        for (int i = 0; i < 16; i++) begin
            logic [63:0] ed;
            @(negedge clk);
            ed = (tbl[i].step >= 0) ? dpat(tbl[i].step) : 64'd0;
            chk($sformatf("t1[%0d] job_ready", i), 64'(job_ready), 64'(tbl[i].jr));
            chk($sformatf("t1[%0d] row_ready", i), 64'(row_ready), 64'(tbl[i].rr));
            chk($sformatf("t1[%0d] weight_en", i), 64'(weight_en), 64'(tbl[i].we));
            chk($sformatf("t1[%0d] input_en", i), 64'(input_en), 64'(tbl[i].ie));
            chk($sformatf("t1[%0d] partial_en", i), 64'(partial_en), 64'(tbl[i].ie));
            chk($sformatf("t1[%0d] job_done", i), 64'(job_done), 64'(tbl[i].jd));
            chk($sformatf("t1[%0d] row_in_en", i), 64'(row_in_en), 64'(tbl[i].idx));
            chk($sformatf("t1[%0d] row_ps_en", i), 64'(row_ps_en), tbl[i].ie ? 64'(tbl[i].idx) : 64'd0);
            chk($sformatf("t1[%0d] array_in", i), array_in, ed);
            chk($sformatf("t1[%0d] partials", i), array_in_partials, tbl[i].ie ? ~ed : 64'd0);
            job_valid = tbl[i].jv; job_has_weights = tbl[i].hw; row_valid = tbl[i].rv;
            drained = tbl[i].dr; fifo_has_space = tbl[i].sp;
            row_data = dpat(i); row_partial = ~dpat(i);
        end

        // Input-only job held off by fifo_has_space
        @(negedge clk);
        job_valid = 1; job_has_weights = 0; fifo_has_space = 0; row_valid = 1;
        @(negedge clk);
        job_valid = 0;
        for (int k = 0; k < 10; k++) begin
            chk("t2 wait row_ready", 64'(row_ready), 64'd0);
            chk("t2 wait strobes", 64'({weight_en, input_en, partial_en}), 64'd0);
            @(negedge clk);
        end
        chk("t2 pre-space row_ready", 64'(row_ready), 64'd0);
        fifo_has_space = 1;
        @(negedge clk);
        chk("t2 load row_ready", 64'(row_ready), 64'd1);
        chk("t2 load no strobe yet", 64'(input_en), 64'd0);
        @(negedge clk);
        chk("t2 first strobe", 64'(input_en), 64'd1);
        chk("t2 first idx", 64'(row_in_en), 64'd0);
        finish_job(1, "t2");

        // row_valid stall inside LOAD_IN
        @(negedge clk);
        job_valid = 1; job_has_weights = 0; fifo_has_space = 1; row_valid = 1;
        @(negedge clk);
        job_valid = 0;
        repeat (2) @(negedge clk);
        chk("t3 row0 strobe", 64'(input_en), 64'd1);
        chk("t3 row0 idx", 64'(row_in_en), 64'd0);
        row_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3 stall strobe", 64'({input_en, partial_en}), 64'd0);
        end
        chk("t3 stall row_ready", 64'(row_ready), 64'd1);
        row_valid = 1;
        @(negedge clk);
        chk("t3 resume strobe", 64'(input_en), 64'd1);
        chk("t3 resume idx", 64'(row_in_en), 64'd1);
        finish_job(2, "t3");
        @(negedge clk);
        row_valid = 0;

        // Full buffer with simultaneous push and pop
        for (int k = 0; k < 4; k++) begin
            out_en = 1; row_out = 2'(k); array_output = opat(k);
            @(negedge clk);
        end
        chk("t5 full valid", 64'(out_valid), 64'd1);
        chk("t5 full overflow", 64'(out_overflow), 64'd0);
        out_en = 1; row_out = 2'(4); array_output = opat(4); out_ready = 1;
        @(negedge clk);
        out_en = 0; out_ready = 0;
        chk("t5 overflow after push+pop", 64'(out_overflow), 64'd0);
        drain_expect(1, 4, "t5");

        // Overflow: five pushes into four entries
        for (int k = 10; k < 15; k++) begin
            out_en = 1; row_out = 2'(k); array_output = opat(k);
            @(negedge clk);
        end
        out_en = 0;
        chk("t4 overflow set", 64'(out_overflow), 64'd1);
        drain_expect(10, 4, "t4");
        chk("t4 overflow sticky", 64'(out_overflow), 64'd1);

        // Reset in the middle of the input phase
        job_valid = 1; job_has_weights = 0; fifo_has_space = 1; row_valid = 1;
        @(negedge clk);
        job_valid = 0;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (input_en && row_in_en == 2'd2) found = 1;
        end
        chk("t6 reached row 2", 64'(found), 64'd1);
        RST = 1;
        #1;
        chk("t6 strobes in reset", 64'({weight_en, input_en, partial_en, job_done}), 64'd0);
        chk("t6 array_in in reset", array_in, 64'd0);
        chk("t6 partials in reset", array_in_partials, 64'd0);
        chk("t6 row_in_en in reset", 64'(row_in_en), 64'd0);
        chk("t6 overflow cleared", 64'(out_overflow), 64'd0);
        @(negedge clk);
        RST = 0;
        row_valid = 1;
        #1;
        chk("t6 job_ready after release", 64'(job_ready), 64'd1);
        job_valid = 1;
        @(negedge clk);
        job_valid = 0;
        finish_job(0, "t6");
        @(negedge clk);
        row_valid = 0;

        // Randomized output-buffer traffic against a queue model
        mq.delete();
        m_ovf = 0;
        for (int c = 0; c < 400; c++) begin
            bit pe, pr, mpop, mpush;
            logic [65:0] ent;
            @(negedge clk);
            chk("rnd out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("rnd overflow", 64'(out_overflow), 64'(m_ovf));
            if (mq.size() > 0) begin
                ent = mq[0];
                chk("rnd out_row", 64'(out_row), 64'(ent[65:64]));
                chk("rnd out_data", out_data, ent[63:0]);
            end
            pe = ($urandom_range(0, 1) == 1);
            pr = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            out_en = pe; out_ready = pr;
            row_out = 2'($urandom_range(0, 3));
            array_output = {$urandom, $urandom};
            mpop  = pr && (mq.size() > 0);
            mpush = pe && ((mq.size() < DEPTH) || mpop);
            if (pe && (mq.size() == DEPTH) && !mpop) m_ovf = 1;
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back({row_out, array_output});
        end
        out_en = 0; out_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
